// File: rtl/alu_pkg.sv
// Shared operation codes, FSM state encoding and decode helpers for the
// iterative EX-stage ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_XOR = 4'b0011,
        OP_SUB = 4'b0100,
        OP_SLT = 4'b0101,
        OP_SLL = 4'b0110,
        OP_SRL = 4'b0111,
        OP_BEQ = 4'b1000,
        OP_SRA = 4'b1001,
        OP_BGE = 4'b1010,
        OP_BNE = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter: loads a word and a count on start, then shifts
// once per cycle until the count is exhausted.
module alu_serial_shifter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_start,
    input  logic [3:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [SHAMT_W-1:0]    i_shamt,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_next
);

    logic [DATA_WIDTH-1:0] r_work;
    logic [SHAMT_W-1:0]    r_cnt;
    logic [3:0]            r_op;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] w_step;

    always_comb begin
        w_step = {1'b0, r_work[DATA_WIDTH-1:1]};
        case (r_op)
            OP_SLL:  w_step = {r_work[DATA_WIDTH-2:0], 1'b0};
            OP_SRA:  w_step = {r_work[DATA_WIDTH-1], r_work[DATA_WIDTH-1:1]};
            default: w_step = {1'b0, r_work[DATA_WIDTH-1:1]};
        endcase
    end

    // o_next is the fully shifted word in the cycle where o_done is high.
    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == SHAMT_W'(1));
    assign o_next = w_step;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_work <= '0;
            r_cnt  <= '0;
            r_op   <= OP_SLL;
            r_busy <= 1'b0;
        end else if (i_flush) begin
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_work <= i_data;
            r_cnt  <= i_shamt;
            r_op   <= i_op;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_work <= w_step;
            r_cnt  <= r_cnt - SHAMT_W'(1);
            if (r_cnt == SHAMT_W'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_iterative_exec.sv
// EX-stage execution unit: single-cycle logic/arith/compare ops, iterative
// shifts, result registered and held behind a valid/ready handshake.
module alu_iterative_exec
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            operation,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  illegal_op,
    output state_e                o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready is high in IDLE, or in DONE while the consumer pops; flush
    // forces it low and wins over both accept and pop.
    state_e                r_state;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_zero;
    logic                  r_illegal;

    logic [SHAMT_W-1:0]    w_shamt;
    logic                  w_accept;
    logic                  w_start;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_ill;
    logic                  w_sh_busy;
    logic                  w_sh_done;
    logic [DATA_WIDTH-1:0] w_sh_next;

    assign w_shamt  = b[SHAMT_W-1:0];
    assign in_ready = !flush && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
    assign w_accept = in_valid && in_ready;
    assign w_start  = w_accept && is_shift(operation) && (w_shamt != '0);
    assign w_pop    = (r_state == DONE) && out_ready && !flush;

    // Shift codes land here only with a zero shift amount, which yields a.
    always_comb begin
        w_res = '0;
        w_ill = 1'b0;
        case (operation)
            OP_AND:                 w_res = a & b;
            OP_OR:                  w_res = a | b;
            OP_ADD:                 w_res = a + b;
            OP_XOR:                 w_res = a ^ b;
            OP_SUB:                 w_res = a - b;
            OP_SLT:                 w_res[0] = $signed(a) < $signed(b);
            OP_BEQ:                 w_res[0] = (a == b);
            OP_BGE:                 w_res[0] = $signed(a) >= $signed(b);
            OP_BNE:                 w_res[0] = (a != b);
            OP_SLL, OP_SRL, OP_SRA: w_res = a;
            default:                w_ill = 1'b1;
        endcase
    end

    alu_serial_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHAMT_W    (SHAMT_W)
    ) u_shifter (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_flush (flush),
        .i_start (w_start),
        .i_op    (operation),
        .i_data  (a),
        .i_shamt (w_shamt),
        .o_busy  (w_sh_busy),
        .o_done  (w_sh_done),
        .o_next  (w_sh_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_state   <= IDLE;
            r_illegal <= 1'b0;
        end else if (w_start) begin
            r_state   <= SHIFT;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_state   <= DONE;
            r_result  <= w_res;
            r_zero    <= (w_res == '0);
            r_illegal <= w_ill;
        end else if ((r_state == SHIFT) && w_sh_busy && w_sh_done) begin
            r_state   <= DONE;
            r_result  <= w_sh_next;
            r_zero    <= (w_sh_next == '0);
            r_illegal <= 1'b0;
        end else if (w_pop) begin
            r_state   <= IDLE;
        end
    end

    assign out_valid   = (r_state == DONE);
    assign result      = r_result;
    assign zero        = r_zero;
    assign illegal_op  = r_illegal;
    assign o_dbg_state = r_state;

endmodule

// File: doc/alu_iterative_exec.md
Name: alu_iterative_exec

Overview:
Execution unit that consumes the 4-bit Operation code produced by the ALU control decode and performs the operation on two operands. It sits in the EX stage behind a valid/ready handshake.
- Logic, add/sub and compare/branch ops complete in one cycle.
- Shifts run iteratively, one bit position per cycle, so the unit needs no barrel shifter.
- Results are registered and held until the consumer accepts them.

Parameters:
DATA_WIDTH, 32, operand/result width in bits.
SHAMT_W, $clog2(DATA_WIDTH), shift-amount width; the shift amount is taken from b[SHAMT_W-1:0].

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
flush  input  1  synchronous abort of any in-flight or held operation.
in_valid  input  1  operands and operation presented.
in_ready  output  1  unit can accept an operation this cycle.
operation  input  4  ALU operation code (encoding below).
a  input  DATA_WIDTH  operand A (rs1).
b  input  DATA_WIDTH  operand B (rs2 or immediate).
out_valid  output  1  result registered and held.
out_ready  input  1  consumer accepts the result.
result  output  DATA_WIDTH  operation result.
zero  output  1  high when result == 0.
illegal_op  output  1  the held result came from an unknown operation code.

Behaviour:
- Operation encoding and result:
  - 0000 AND: a&b. 0001 OR: a|b. 0010 ADD: a+b, wraps mod 2^DATA_WIDTH. 0011 XOR: a^b. 0100 SUB: a-b, wraps.
  - 0101 SLT/BLT: 1 if signed a<b, else 0. 1000 BEQ: 1 if a==b. 1010 BGE: 1 if signed a>=b. 1100 BNE: 1 if a!=b.
  - 0110 SLL, 0111 SRL (zero fill), 1001 SRA (sign fill): shift by b[SHAMT_W-1:0].
  - All compare ops return zero-extended 1 or 0 in bit 0.
  - Any other code: result=0, illegal_op=1, one-cycle path.
- Reset (asynchronous):
  - state=IDLE; out_valid=0, result=0, zero=0, illegal_op=0.
  - in_ready is 1 once reset deasserts.
- States: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. On accept (in_valid && in_ready):
    - Non-shift op, or shift with shamt=0: result registered; go to DONE. out_valid rises the next cycle (latency 1).
    - Shift with shamt>0: latch a into the work register, shamt into a down-counter and the op; go to SHIFT.
  - SHIFT: each cycle shift the work register by 1 in the latched direction/fill and decrement the counter. When the counter reaches 0, go to DONE with result = work register. Shift latency = shamt+1 cycles from accept to out_valid. in_ready=0 throughout.
  - DONE: out_valid=1; result, zero and illegal_op are stable.
    - out_ready=1 pops the result; in_ready = out_ready in this state, so a back-to-back accept in the same cycle is allowed and follows the IDLE rules.
    - Pop with no new accept: go to IDLE.
    - out_ready=0: hold with no change and in_ready=0.
- Inputs are sampled only on accept. Changes to operation/a/b after accept have no effect.
- flush:
  - Go to IDLE and clear out_valid and illegal_op. result keeps its value but is don't-care.
  - Takes priority over a simultaneous accept, which is not performed; in_ready is forced to 0 while flush=1.
  - Takes priority over a simultaneous pop.
  - Mid-shift flush discards the partial result.
- Reset mid-shift: immediate return to the reset values; no partial result escapes.
- zero and illegal_op are registered together with result.

Decomposition:
- Package alu_pkg holds:
  - alu_op_e: 4-bit enum of the operation codes above.
  - state_e: {IDLE, SHIFT, DONE}.
  - Helper function is_shift(op).
- Sub-module alu_serial_shifter holds the work register, the down-counter and the one-bit-per-cycle shift step with start/done. It is instantiated once.

Test Plan:
- Reset, then ADD a=0xFFFFFFFF, b=0x00000001 -> one cycle later out_valid=1, result=0x00000000, zero=1.
- SRA a=0x80000000, b=4 -> in_ready=0 for 4 cycles; out_valid in cycle 5, result=0xF8000000. SRL with the same operands -> 0x08000000.
- SLT a=0xFFFFFFFF (-1), b=1 -> result=1. BGE with the same operands -> result=0. BNE a=b=5 -> result=0, zero=1.
- Back-to-back: SUB 10-3 held with out_ready=0 for 3 cycles, so the result stays 7; then out_ready=1 with a new XOR 0xF0^0xFF presented -> next result 0x0F and no lost cycle.
- Flush on the 3rd cycle of SLL a=1, b=31 -> next cycle IDLE, out_valid stays 0, in_ready=1. A subsequent AND 0xC&0xA gives 0x8.
- Illegal code 4'b1111 -> result=0, illegal_op=1. Async reset asserted mid-SHIFT -> all outputs at reset values immediately.
